// File: rtl/alt_sensor_poll_seq.sv
// alt_sensor_poll_seq: configures an MPL3115A2-class sensor over a byte-level
// I2C master, polls its status register and publishes pressure/temperature
// samples together with per-channel delta, min and max.
module alt_sensor_poll_seq #(
    parameter logic [6:0] DEV_ADDR   = 7'h60,
    parameter logic [7:0] CTRL1_CFG  = 8'hB8,
    parameter logic [7:0] PT_CFG     = 8'h07,
    parameter int         P_W        = 20,
    parameter int         T_W        = 12,
    parameter int         POLL_DIV   = 1000,
    parameter int         RETRY_WAIT = 10000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           clr_stats,
    output logic           i2c_ena,
    output logic [6:0]     i2c_addr,
    output logic           i2c_rw,
    output logic [7:0]     i2c_data_wr,
    input  logic [7:0]     i2c_data_rd,
    input  logic           i2c_busy,
    input  logic           i2c_ack_err,
    output logic [P_W-1:0] pressure,
    output logic [T_W-1:0] temp,
    output logic [P_W-1:0] delta_pressure,
    output logic [T_W-1:0] delta_temp,
    output logic [P_W-1:0] min_pressure,
    output logic [P_W-1:0] max_pressure,
    output logic [T_W-1:0] min_temp,
    output logic [T_W-1:0] max_temp,
    output logic           sample_valid,
    output logic           init_done,
    output logic           err,
    output logic [7:0]     err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT      = 3'd1,
        S_POLL_WAIT = 3'd2,
        S_RD_STAT   = 3'd3,
        S_RD_DATA   = 3'd4,
        S_UPDATE    = 3'd5,
        S_ERR_STOP  = 3'd6,
        S_ERR_WAIT  = 3'd7
    } state_t;

    state_t          state_r, state_next_s;
    logic            busy_d_r;
    logic            xact_busy_r;
    logic            xact_rd_r;
    logic [7:0]      xact_val_r;
    logic [2:0]      rise_cnt_r, fall_cnt_r, total_r;
    logic [1:0]      init_idx_r;
    logic [31:0]     wait_cnt_r;
    logic [4:0][7:0] rbuf_r;
    logic            seed_r, have_prev_r;

    logic            rise_s, fall_s, done_s, nack_s, start_s, wait_done_s;
    logic            xact_state_s, xact_rd_s;
    logic [7:0]      xact_reg_s, xact_wval_s;
    logic [2:0]      xact_total_s;
    logic [23:0]     raw_p_s;
    logic [15:0]     raw_t_s;
    logic [P_W-1:0]  p_new_s;
    logic [T_W-1:0]  t_new_s;
    logic            seed_s;
    logic            unused_s;

    // Busy edge detection and transaction completion/error qualifiers
    always_comb begin
        rise_s  = i2c_busy & ~busy_d_r;
        fall_s  = ~i2c_busy & busy_d_r;
        done_s  = xact_busy_r & fall_s & ~i2c_ack_err & ((fall_cnt_r + 3'd1) == total_r);
        nack_s  = xact_busy_r & fall_s & i2c_ack_err;
        raw_p_s = {rbuf_r[0], rbuf_r[1], rbuf_r[2]};
        raw_t_s = {rbuf_r[3], rbuf_r[4]};
        p_new_s = raw_p_s[23 -: P_W];
        t_new_s = raw_t_s[15 -: T_W];
        seed_s  = seed_r | clr_stats;
        unused_s = ^{raw_p_s, raw_t_s};
        if (state_r == S_POLL_WAIT) begin
            wait_done_s = (wait_cnt_r == 32'(POLL_DIV - 1));
        end else if (state_r == S_ERR_WAIT) begin
            wait_done_s = (wait_cnt_r == 32'(RETRY_WAIT - 1));
        end else begin
            wait_done_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (en) state_next_s = init_done ? S_POLL_WAIT : S_INIT;
                else    state_next_s = S_IDLE;
            end
            S_INIT: begin
                if (nack_s)                             state_next_s = S_ERR_STOP;
                else if (done_s && init_idx_r == 2'd2)  state_next_s = S_POLL_WAIT;
                else                                    state_next_s = S_INIT;
            end
            S_POLL_WAIT: begin
                if (!en)              state_next_s = S_IDLE;
                else if (wait_done_s) state_next_s = S_RD_STAT;
                else                  state_next_s = S_POLL_WAIT;
            end
            S_RD_STAT: begin
                if (nack_s)      state_next_s = S_ERR_STOP;
                else if (done_s) state_next_s = i2c_data_rd[3] ? S_RD_DATA : S_POLL_WAIT;
                else             state_next_s = S_RD_STAT;
            end
            S_RD_DATA: begin
                if (nack_s)      state_next_s = S_ERR_STOP;
                else if (done_s) state_next_s = S_UPDATE;
                else             state_next_s = S_RD_DATA;
            end
            S_UPDATE:   state_next_s = S_POLL_WAIT;
            S_ERR_STOP: begin
                if (!i2c_busy) state_next_s = S_ERR_WAIT;
                else           state_next_s = S_ERR_STOP;
            end
            S_ERR_WAIT: begin
                if (wait_done_s) state_next_s = S_INIT;
                else             state_next_s = S_ERR_WAIT;
            end
            default:    state_next_s = S_IDLE;
        endcase
    end

    // Per-state transaction descriptor and launch condition
    always_comb begin
        xact_state_s = 1'b0;
        xact_rd_s    = 1'b0;
        xact_reg_s   = 8'h00;
        xact_wval_s  = 8'h00;
        xact_total_s = 3'd2;
        case (state_r)
            S_INIT: begin
                xact_state_s = 1'b1;
                case (init_idx_r)
                    2'd0:    begin xact_reg_s = 8'h26; xact_wval_s = CTRL1_CFG;         end
                    2'd1:    begin xact_reg_s = 8'h13; xact_wval_s = PT_CFG;            end
                    default: begin xact_reg_s = 8'h26; xact_wval_s = CTRL1_CFG | 8'h01; end
                endcase
            end
            S_RD_STAT: begin
                xact_state_s = 1'b1;
                xact_rd_s    = 1'b1;
                xact_reg_s   = 8'h00;
                xact_total_s = 3'd2;
            end
            S_RD_DATA: begin
                xact_state_s = 1'b1;
                xact_rd_s    = 1'b1;
                xact_reg_s   = 8'h01;
                xact_total_s = 3'd6;
            end
            default: xact_state_s = 1'b0;
        endcase
        start_s = xact_state_s & ~xact_busy_r & ~i2c_busy;
    end

    // Transaction engine: launches requests, advances bytes on busy edges, captures reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_d_r    <= 1'b0;
            xact_busy_r <= 1'b0;
            xact_rd_r   <= 1'b0;
            xact_val_r  <= 8'h00;
            rise_cnt_r  <= 3'd0;
            fall_cnt_r  <= 3'd0;
            total_r     <= 3'd0;
            rbuf_r      <= {5{8'h00}};
            i2c_ena     <= 1'b0;
            i2c_addr    <= 7'h00;
            i2c_rw      <= 1'b0;
            i2c_data_wr <= 8'h00;
        end else begin
            busy_d_r <= i2c_busy;
            if (start_s) begin
                xact_busy_r <= 1'b1;
                xact_rd_r   <= xact_rd_s;
                xact_val_r  <= xact_wval_s;
                total_r     <= xact_total_s;
                rise_cnt_r  <= 3'd0;
                fall_cnt_r  <= 3'd0;
                i2c_ena     <= 1'b1;
                i2c_addr    <= DEV_ADDR;
                i2c_rw      <= 1'b0;
                i2c_data_wr <= xact_reg_s;
            end else if (xact_busy_r) begin
                if (rise_s) begin
                    if ((rise_cnt_r + 3'd1) < total_r) begin
                        rise_cnt_r <= rise_cnt_r + 3'd1;
                        i2c_rw     <= xact_rd_r;
                        if (!xact_rd_r) i2c_data_wr <= xact_val_r;
                        else            i2c_data_wr <= i2c_data_wr;
                    end else begin
                        i2c_ena <= 1'b0;
                    end
                end else if (fall_s) begin
                    if (i2c_ack_err) begin
                        i2c_ena     <= 1'b0;
                        xact_busy_r <= 1'b0;
                    end else begin
                        fall_cnt_r <= fall_cnt_r + 3'd1;
                        if (xact_rd_r && fall_cnt_r != 3'd0) rbuf_r[fall_cnt_r - 3'd1] <= i2c_data_rd;
                        else                                 rbuf_r <= rbuf_r;
                        if ((fall_cnt_r + 3'd1) == total_r) xact_busy_r <= 1'b0;
                        else                                xact_busy_r <= 1'b1;
                    end
                end else begin
                    xact_busy_r <= 1'b1;
                end
            end else begin
                xact_busy_r <= 1'b0;
            end
        end
    end

    // Sequencer bookkeeping: init step index and the poll/retry wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_idx_r <= 2'd0;
            wait_cnt_r <= 32'd0;
        end else begin
            if (state_r != S_INIT) init_idx_r <= 2'd0;
            else if (done_s)       init_idx_r <= init_idx_r + 2'd1;
            else                   init_idx_r <= init_idx_r;
            if (state_next_s != state_r)                            wait_cnt_r <= 32'd0;
            else if (state_r == S_POLL_WAIT || state_r == S_ERR_WAIT) wait_cnt_r <= wait_cnt_r + 32'd1;
            else                                                    wait_cnt_r <= 32'd0;
        end
    end

    // Status flags: init completion, sticky error and saturating NACK count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            if (state_r == S_INIT && done_s && init_idx_r == 2'd2) init_done <= 1'b1;
            else if (state_r == S_ERR_WAIT && wait_done_s)         init_done <= 1'b0;
            else                                                   init_done <= init_done;
            if (nack_s) begin
                err <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                else                  err_cnt <= err_cnt;
            end else if (state_r == S_UPDATE) begin
                err <= 1'b0;
            end else begin
                err <= err;
            end
        end
    end

    // Sample publication: value, delta against previous, signed min/max tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pressure       <= {P_W{1'b0}};
            temp           <= {T_W{1'b0}};
            delta_pressure <= {P_W{1'b0}};
            delta_temp     <= {T_W{1'b0}};
            min_pressure   <= {P_W{1'b0}};
            max_pressure   <= {P_W{1'b0}};
            min_temp       <= {T_W{1'b0}};
            max_temp       <= {T_W{1'b0}};
            sample_valid   <= 1'b0;
            seed_r         <= 1'b1;
            have_prev_r    <= 1'b0;
        end else if (state_r == S_UPDATE) begin
            pressure     <= p_new_s;
            temp         <= t_new_s;
            sample_valid <= 1'b1;
            seed_r       <= 1'b0;
            have_prev_r  <= 1'b1;
            if (have_prev_r) begin
                delta_pressure <= p_new_s - pressure;
                delta_temp     <= t_new_s - temp;
            end else begin
                delta_pressure <= {P_W{1'b0}};
                delta_temp     <= {T_W{1'b0}};
            end
            if (seed_s || $signed(p_new_s) < $signed(min_pressure)) min_pressure <= p_new_s;
            else                                                      min_pressure <= min_pressure;
            if (seed_s || $signed(p_new_s) > $signed(max_pressure)) max_pressure <= p_new_s;
            else                                                      max_pressure <= max_pressure;
            if (seed_s || $signed(t_new_s) < $signed(min_temp)) min_temp <= t_new_s;
            else                                                  min_temp <= min_temp;
            if (seed_s || $signed(t_new_s) > $signed(max_temp)) max_temp <= t_new_s;
            else                                                  max_temp <= max_temp;
        end else begin
            sample_valid <= 1'b0;
            if (clr_stats) seed_r <= 1'b1;
            else           seed_r <= seed_r;
        end
    end

endmodule

// File: tb/tb_alt_sensor_poll_seq.sv
// tb_alt_sensor_poll_seq: directed bench with a byte-level I2C master model
// that logs bus activity as tokens (0x1xx start+address byte, 0x0xx write
// data, 0x200 read byte, 0x300 stop) and returns queued read data.
module tb_alt_sensor_poll_seq;
    localparam int P_W = 20, T_W = 12, POLL_DIV = 40, RETRY_WAIT = 100;

    logic           clk = 1'b0;
    logic           rst_n, en, clr_stats;
    logic           i2c_ena, i2c_rw, i2c_busy, i2c_ack_err;
    logic [6:0]     i2c_addr;
    logic [7:0]     i2c_data_wr, i2c_data_rd;
    logic [P_W-1:0] pressure, delta_pressure, min_pressure, max_pressure;
    logic [T_W-1:0] temp, delta_temp, min_temp, max_temp;
    logic           sample_valid, init_done, err;
    logic [7:0]     err_cnt;

    int          vectors = 0, miscompares = 0;
    logic [7:0]  rd_q[$];
    logic [15:0] log_q[$];
    int          st_q[$];
    int          nack_in = 0, rd_seen = 0, cyc = 0;
    bit          nack_fired = 1'b0;

    alt_sensor_poll_seq #(.POLL_DIV(POLL_DIV), .RETRY_WAIT(RETRY_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_stats(clr_stats),
        .i2c_ena(i2c_ena), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw), .i2c_data_wr(i2c_data_wr),
        .i2c_data_rd(i2c_data_rd), .i2c_busy(i2c_busy), .i2c_ack_err(i2c_ack_err),
        .pressure(pressure), .temp(temp), .delta_pressure(delta_pressure), .delta_temp(delta_temp),
        .min_pressure(min_pressure), .max_pressure(max_pressure), .min_temp(min_temp), .max_temp(max_temp),
        .sample_valid(sample_valid), .init_done(init_done), .err(err), .err_cnt(err_cnt));

    always #5 clk = ~clk;

    // Free-running cycle stamp for transaction spacing
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag, input int base, input logic [15:0] e[$]);
        logic [15:0] o;
        chk({tag, "_len"}, 128'(log_q.size() >= base + e.size()), 128'd1);
        for (int i = 0; i < e.size(); i++) begin
            o = (base + i < log_q.size()) ? log_q[base + i] : 16'hDEAD;
            chk($sformatf("%s_tok%0d", tag, i), 128'(o), 128'(e[i]));
        end
    endtask

    task automatic wait_sample(input string tag, input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while (sample_valid !== 1'b1 && n < budget);
        chk({tag, "_sample_seen"}, 128'(sample_valid), 128'd1);
    endtask

    task automatic wait_init(input string tag, input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while (init_done !== 1'b1 && n < budget);
        chk({tag, "_init_done"}, 128'(init_done), 128'd1);
    endtask

    // I2C master model: one busy pulse per byte, reads popped from rd_q
    initial begin : master_model
        logic cur_rw, first, nack_now, more;
        i2c_busy = 1'b0; i2c_data_rd = 8'h00; i2c_ack_err = 1'b0;
        forever begin
            @(negedge clk);
            if (i2c_ena === 1'b1 && i2c_busy === 1'b0) begin
                log_q.push_back({8'h01, i2c_addr, i2c_rw});
                st_q.push_back(cyc);
                nack_now = 1'b0;
                if (nack_in > 0) begin nack_in--; nack_now = (nack_in == 0); end
                cur_rw = i2c_rw; first = 1'b1; more = 1'b1;
                while (more) begin
                    i2c_busy = 1'b1;
                    if (cur_rw) begin log_q.push_back(16'h0200); rd_seen++; end
                    else log_q.push_back({8'h00, i2c_data_wr});
                    repeat (4) @(negedge clk);
                    i2c_busy = 1'b0;
                    i2c_ack_err = first & nack_now;
                    if (first && nack_now) nack_fired = 1'b1;
                    if (cur_rw) i2c_data_rd = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
                    @(negedge clk);
                    i2c_ack_err = 1'b0; first = 1'b0;
                    if (i2c_ena !== 1'b1) begin
                        log_q.push_back(16'h0300); more = 1'b0;
                    end else if (i2c_rw !== cur_rw) begin
                        log_q.push_back({8'h01, i2c_addr, i2c_rw}); cur_rw = i2c_rw;
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [15:0] e[$];
        int n, base, sz0;
        rst_n = 1'b0; en = 1'b0; clr_stats = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ena_addr", {i2c_ena, i2c_addr, i2c_rw, i2c_data_wr}, 128'd0);
        chk("rst_data", {pressure, temp, delta_pressure, delta_temp}, 128'd0);
        chk("rst_minmax", {min_pressure, max_pressure, min_temp, max_temp}, 128'd0);
        chk("rst_flags", {sample_valid, init_done, err, err_cnt}, 128'd0);

        // Init sequence, then two not-ready polls before a ready one
        rst_n = 1'b1;
        rd_q = '{8'h00, 8'h00, 8'h08, 8'h12, 8'h34, 8'h56, 8'h7A, 8'hB0};
        @(negedge clk); en = 1'b1;
        wait_init("init", 500);
        @(negedge clk);
        e = '{16'h1C0, 16'h026, 16'h0B8, 16'h300, 16'h1C0, 16'h013, 16'h007, 16'h300,
              16'h1C0, 16'h026, 16'h0B9, 16'h300};
        check_log("init", 0, e);
        chk("init_err", {err, err_cnt}, 128'd0);

        wait_sample("s1", 2000);
        chk("s1_p", 128'(pressure), 128'h12345);
        chk("s1_t", 128'(temp), 128'h7AB);
        chk("s1_delta", {delta_pressure, delta_temp}, 128'd0);
        chk("s1_minmax", {min_pressure, max_pressure, min_temp, max_temp},
            {20'h12345, 20'h12345, 12'h7AB, 12'h7AB});
        e = '{16'h1C0, 16'h000, 16'h1C1, 16'h200, 16'h300,
              16'h1C0, 16'h000, 16'h1C1, 16'h200, 16'h300,
              16'h1C0, 16'h000, 16'h1C1, 16'h200, 16'h300,
              16'h1C0, 16'h001, 16'h1C1, 16'h200, 16'h200, 16'h200, 16'h200, 16'h200, 16'h300};
        check_log("poll", 12, e);
        n = (st_q.size() > 4) ? st_q[4] - st_q[3] : 0;
        chk("poll_gap", 128'(n >= POLL_DIV && n <= POLL_DIV + 40), 128'd1);
        @(negedge clk);
        chk("s1_pulse_len", 128'(sample_valid), 128'd0);

        // Second sample: deltas and signed min/max movement
        rd_q = '{8'h08, 8'h12, 8'h34, 8'h76, 8'h7A, 8'h90};
        wait_sample("s2", 2000);
        chk("s2_pt", {pressure, temp}, {20'h12347, 12'h7A9});
        chk("s2_delta", {delta_pressure, delta_temp}, {20'h00002, 12'hFFE});
        chk("s2_minmax", {min_pressure, max_pressure, min_temp, max_temp},
            {20'h12345, 20'h12347, 12'h7A9, 12'h7AB});

        // clr_stats between samples re-seeds min/max with a negative pressure
        @(negedge clk); clr_stats = 1'b1;
        @(negedge clk); clr_stats = 1'b0;
        rd_q = '{8'h08, 8'h80, 8'h00, 8'h00, 8'h7A, 8'h90};
        wait_sample("s3", 2000);
        chk("s3_p", 128'(pressure), 128'h80000);
        chk("s3_delta", {delta_pressure, delta_temp}, {20'h6DCB9, 12'h000});
        chk("s3_minmax", {min_pressure, max_pressure, min_temp, max_temp},
            {20'h80000, 20'h80000, 12'h7A9, 12'h7A9});

        // en low: block idles; re-enable resumes polling without re-init
        en = 1'b0;
        sz0 = log_q.size();
        repeat (3 * POLL_DIV) @(negedge clk);
        chk("idle_quiet", {31'(log_q.size() - sz0), i2c_ena}, 128'd0);
        rd_q = '{8'h08, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        base = rd_seen;
        en = 1'b1;
        n = 0;
        while (log_q.size() < sz0 + 2 && n < 500) begin @(negedge clk); n++; end
        chk("reen_start", 128'((log_q.size() > sz0) ? log_q[sz0] : 16'hDEAD), 128'h1C0);
        chk("reen_reg", 128'((log_q.size() > sz0 + 1) ? log_q[sz0 + 1] : 16'hDEAD), 128'h000);

        // Asynchronous reset in the middle of the third data byte
        n = 0;
        while (rd_seen < base + 4 && n < 1000) begin @(negedge clk); n++; end
        chk("rd3_reached", 128'(rd_seen >= base + 4), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_ena", 128'(i2c_ena), 128'd0);
        chk("arst_data", {pressure, temp, delta_pressure, delta_temp}, 128'd0);
        chk("arst_minmax", {min_pressure, max_pressure, min_temp, max_temp}, 128'd0);
        chk("arst_flags", {sample_valid, init_done, err, err_cnt}, 128'd0);
        repeat (10) @(negedge clk);
        rd_q.delete(); log_q.delete(); st_q.delete();
        nack_in = 2;
        rst_n = 1'b1;

        // NACK on the address byte of the second init write, then retry
        n = 0;
        while (!nack_fired && n < 500) begin @(negedge clk); n++; end
        chk("nack_fired", 128'(nack_fired), 128'd1);
        repeat (3) @(negedge clk);
        chk("nack_state", {i2c_ena, err, err_cnt, init_done}, {1'b0, 1'b1, 8'd1, 1'b0});
        wait_init("retry", RETRY_WAIT + 500);
        @(negedge clk);
        e = '{16'h1C0, 16'h026, 16'h0B8, 16'h300, 16'h1C0, 16'h013, 16'h300,
              16'h1C0, 16'h026, 16'h0B8, 16'h300, 16'h1C0, 16'h013, 16'h007, 16'h300,
              16'h1C0, 16'h026, 16'h0B9, 16'h300};
        check_log("retry", 0, e);
        chk("retry_err_held", {err, err_cnt}, {1'b1, 8'd1});
        rd_q = '{8'h08, 8'h12, 8'h34, 8'h56, 8'h7A, 8'hB0};
        wait_sample("s4", 2000);
        chk("s4_err", {err, err_cnt}, {1'b0, 8'd1});
        chk("s4_pt", {pressure, temp}, {20'h12345, 12'h7AB});
        chk("s4_first", {delta_pressure, delta_temp, min_pressure, max_pressure},
            {20'h0, 12'h0, 20'h12345, 20'h12345});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alt_sensor_poll_seq.md
Name: alt_sensor_poll_seq

Overview:
- Parametrised successor to the single-sequence altimeter controller. Autonomously configures an MPL3115A2-class I2C pressure/temperature sensor and polls its status register.
- When data is ready, burst-reads the data registers and publishes pressure and temperature. Also publishes per-channel delta, min and max.
- Sits between the system fabric and the byte-level I2C master (ena/busy/data_rd/ack_err handshake), which owns SCL/SDA.

Parameters:
- DEV_ADDR, 7'h60, 7-bit sensor slave address.
- CTRL1_CFG, 8'hB8, CTRL_REG1 standby configuration. Bit0 is forced 1 for the activate write.
- PT_CFG, 8'h07, value written to PT_DATA_CFG (reg 0x13).
- P_W, 20, pressure/altitude width, 1..24. Taken MSB-aligned from the 3 data bytes.
- T_W, 12, temperature width, 1..16. Taken MSB-aligned from the 2 data bytes.
- POLL_DIV, 1000, idle clocks between status polls (>=1).
- RETRY_WAIT, 10000, clocks to wait after an error before re-running init.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; on deassert, the current transaction completes, then the block idles
- clr_stats  in  1  one-cycle pulse; restarts min/max tracking
- i2c_ena  out  1  transaction request to I2C master
- i2c_addr  out  7  slave address
- i2c_rw  out  1  1=read, 0=write
- i2c_data_wr  out  8  byte to write
- i2c_data_rd  in  8  byte read; valid at busy falling edge
- i2c_busy  in  1  master busy
- i2c_ack_err  in  1  NACK flag; sampled at busy falling edge
- pressure  out  P_W  latest pressure, signed
- temp  out  T_W  latest temperature, signed
- delta_pressure  out  P_W  current minus previous pressure, mod 2^P_W
- delta_temp  out  T_W  current minus previous temperature, mod 2^T_W
- min_pressure, max_pressure  out  P_W  signed extremes
- min_temp, max_temp  out  T_W  signed extremes
- sample_valid  out  1  one-cycle pulse; all data outputs updated the same cycle
- init_done  out  1  high once the activate write has completed
- err  out  1  sticky; set on NACK, cleared on the next sample_valid
- err_cnt  out  8  NACK count, saturates at 255

Behaviour:
- Reset: all outputs 0, FSM in IDLE, first-sample flag set.
- Master handshake:
  - Raise i2c_ena with addr/rw/data_wr valid.
  - On each busy rising edge (registered busy_d): if more bytes remain, present the next rw/data_wr; otherwise drop i2c_ena (stop issued after the current byte).
  - A change of rw while ena is held produces a repeated start.
  - Read bytes are captured on busy falling edges.
- Transactions:
  - WR(reg,val) = write reg, write val.
  - RD(reg,n) = write reg, repeated-start read n bytes.
- FSM:
  - IDLE -> INIT when en=1.
  - INIT: WR(0x26,CTRL1_CFG), WR(0x13,PT_CFG), WR(0x26,CTRL1_CFG|1), using init index 0..2. init_done is set at completion of the third write, then go to POLL_WAIT.
  - POLL_WAIT: count POLL_DIV clocks -> RD_STAT.
  - RD_STAT: RD(0x00,1). If bit3 (PTDR) is set -> RD_DATA, else POLL_WAIT.
  - RD_DATA: RD(0x01,5) into b0..b4 -> UPDATE.
  - UPDATE (1 cycle): apply the data update rules below -> POLL_WAIT.
- UPDATE data rules:
  - pressure = {b0,b1,b2}[23 -: P_W]; temp = {b3,b4}[15 -: T_W].
  - delta = new - old. On the first sample, delta = 0 and min = max = sample.
  - Otherwise min/max update by signed compare.
  - Pulse sample_valid. Clear err.
- en=0 is sampled only in POLL_WAIT/IDLE boundaries: the block finishes the current transaction and goes to IDLE. init_done is kept; re-enable goes straight to POLL_WAIT.
- NACK handling: on ack_err at a busy falling edge:
  - Drop ena immediately, set err, increment err_cnt (saturating).
  - Go to ERR_STOP and wait for busy=0.
  - Then ERR_WAIT for RETRY_WAIT clocks. Clear init_done, then go to INIT.
- clr_stats: sets the first-sample flag. If it coincides with UPDATE, that sample seeds min/max.
- Reset mid-transaction drops i2c_ena asynchronously. The master is expected to finish or abort on its own.
- busy glitch-free assumption: one rising and one falling edge per byte. ena is never raised while busy=1.

Test Plan:
- Init: en=1, model ACKs everything -> bytes in order C0:26,B8 stop; C0:13,07 stop; C0:26,B9 stop. init_done rises after the last busy falling edge.
- Not-ready poll: status reads 0x00 twice, then 0x08 -> two RD_STAT transactions spaced POLL_DIV+overhead apart. The third is followed by C0:01, repeated start, C1 with 5 reads.
- Samples (defaults):
  - Data 12,34,56,7A,B0 -> pressure=0x12345, temp=0x7AB, delta=0, min=max=sample, one sample_valid pulse.
  - Next data 12,34,76,7A,90 -> pressure=0x12347, delta_pressure=2, temp=0x7A9, delta_temp=0xFFE, min_temp=0x7A9, max_pressure=0x12347.
- NACK: ack_err on the device-address byte of the second init write -> ena drops, err=1, err_cnt=1. After RETRY_WAIT, init restarts from WR(0x26). The next good sample clears err.
- clr_stats between samples, then a sample 0x80000 -> min_pressure=max_pressure=0x80000 (negative), delta vs previous still computed.
- rst_n low during RD_DATA byte 3 -> all outputs 0 immediately, i2c_ena=0. After release with en=1, the full init sequence replays.
